// File: rtl/ras_spec_stack.sv
// Speculative return-address stack with a committed shadow copy and an in-order queue
// of pending actions, so a squash can roll the speculative stack back to committed state.
module ras_spec_stack #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 32,
    parameter int PEND_DEPTH = 8,
    parameter bit OVF_WRAP   = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            trigger,
    input  logic                            push_i,
    input  logic                            pop_i,
    input  logic [WIDTH-1:0]                data_i,
    output logic                            ready_o,
    input  logic                            commit,
    input  logic                            squash,
    output logic [WIDTH-1:0]                top_o,
    output logic                            valid_o,
    output logic [$clog2(DEPTH+1)-1:0]      spec_count_o,
    output logic [$clog2(DEPTH+1)-1:0]      cmt_count_o,
    output logic [$clog2(PEND_DEPTH+1)-1:0] pend_count_o,
    output logic                            overflow_o,
    output logic                            underflow_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int QW  = $clog2(PEND_DEPTH);
    localparam int PCW = $clog2(PEND_DEPTH+1);

    typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_REPL} op_t;

    logic [WIDTH-1:0] spec_arr [DEPTH];
    logic [WIDTH-1:0] cmt_arr  [DEPTH];
    logic [PW-1:0]    spec_ptr, cmt_ptr;
    logic [CW-1:0]    spec_cnt, cmt_cnt;

    op_t              q_op   [PEND_DEPTH];
    logic [WIDTH-1:0] q_data [PEND_DEPTH];
    logic [QW-1:0]    q_wr, q_rd;
    logic [PCW-1:0]   pend_cnt;
    logic             ovf_q, unf_q;

    logic             accept, do_commit;
    op_t              new_op, spec_op, cmt_op;
    logic             ovf_n, unf_n;
    logic [PW-1:0]    spec_ptr_n, cmt_ptr_n;
    logic [CW-1:0]    spec_cnt_n, cmt_cnt_n;
    logic             spec_we, cmt_we;
    logic [WIDTH-1:0] cmt_data;

    assign ready_o   = (pend_cnt != PCW'(PEND_DEPTH));
    assign accept    = trigger && ready_o && !squash;
    assign do_commit = commit && (pend_cnt != '0);

    // Classify the incoming action against the current speculative occupancy.
    always_comb begin
        new_op = OP_NOP;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        if (pop_i && !push_i) begin
            if (spec_cnt != '0) new_op = OP_POP;
            else                unf_n  = 1'b1;
        end else if (push_i && pop_i && spec_cnt != '0) begin
            new_op = OP_REPL;
        end else if (push_i) begin
            if (spec_cnt != CW'(DEPTH)) begin
                new_op = OP_PUSH;
            end else begin
                ovf_n  = 1'b1;
                new_op = OVF_WRAP ? OP_PUSH : OP_NOP;
            end
        end
    end

    assign spec_op  = accept ? new_op : OP_NOP;
    assign cmt_op   = do_commit ? q_op[q_rd] : OP_NOP;
    assign cmt_data = q_data[q_rd];

    // Both stacks share one update rule; the write address is always the new top.
    always_comb begin
        spec_ptr_n = spec_ptr;
        spec_cnt_n = spec_cnt;
        case (spec_op)
            OP_PUSH: begin
                spec_ptr_n = spec_ptr + PW'(1);
                spec_cnt_n = (spec_cnt == CW'(DEPTH)) ? spec_cnt : spec_cnt + CW'(1);
            end
            OP_POP: begin
                spec_ptr_n = spec_ptr - PW'(1);
                spec_cnt_n = (spec_cnt == '0) ? spec_cnt : spec_cnt - CW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        cmt_ptr_n = cmt_ptr;
        cmt_cnt_n = cmt_cnt;
        case (cmt_op)
            OP_PUSH: begin
                cmt_ptr_n = cmt_ptr + PW'(1);
                cmt_cnt_n = (cmt_cnt == CW'(DEPTH)) ? cmt_cnt : cmt_cnt + CW'(1);
            end
            OP_POP: begin
                cmt_ptr_n = cmt_ptr - PW'(1);
                cmt_cnt_n = (cmt_cnt == '0) ? cmt_cnt : cmt_cnt - CW'(1);
            end
            default: ;
        endcase
    end

    assign spec_we = (spec_op == OP_PUSH) || (spec_op == OP_REPL);
    assign cmt_we  = (cmt_op == OP_PUSH) || (cmt_op == OP_REPL);

    always_ff @(posedge clk) begin
        if (reset) begin
            spec_ptr <= '0;
            spec_cnt <= '0;
            cmt_ptr  <= '0;
            cmt_cnt  <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            pend_cnt <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            cmt_ptr <= cmt_ptr_n;
            cmt_cnt <= cmt_cnt_n;
            ovf_q   <= accept && ovf_n;
            unf_q   <= accept && unf_n;
            if (squash) begin
                spec_ptr <= cmt_ptr_n;
                spec_cnt <= cmt_cnt_n;
                q_wr     <= '0;
                q_rd     <= '0;
                pend_cnt <= '0;
            end else begin
                spec_ptr <= spec_ptr_n;
                spec_cnt <= spec_cnt_n;
                if (accept)    q_wr <= q_wr + QW'(1);
                if (do_commit) q_rd <= q_rd + QW'(1);
                pend_cnt <= pend_cnt + PCW'(accept) - PCW'(do_commit);
            end
        end
    end

    // Storage arrays need no reset; a squash rebuilds spec from the post-commit image.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (cmt_we) cmt_arr[cmt_ptr_n] <= cmt_data;
            if (squash) begin
                spec_arr <= cmt_arr;
                if (cmt_we) spec_arr[cmt_ptr_n] <= cmt_data;
            end else if (spec_we) begin
                spec_arr[spec_ptr_n] <= data_i;
            end
            if (accept) begin
                q_op[q_wr]   <= new_op;
                q_data[q_wr] <= data_i;
            end
        end
    end

    assign valid_o      = (spec_cnt != '0);
    assign top_o        = valid_o ? spec_arr[spec_ptr] : '0;
    assign spec_count_o = spec_cnt;
    assign cmt_count_o  = cmt_cnt;
    assign pend_count_o = pend_cnt;
    assign overflow_o   = ovf_q;
    assign underflow_o  = unf_q;
endmodule

// File: tb/tb_ras_spec_stack.sv
// Directed bench for ras_spec_stack: a default instance plus two DEPTH=4 instances
// (wrap and drop overflow modes) sharing one stimulus stream.
module tb_ras_spec_stack;
    logic        clk = 1'b0;
    logic        reset, trigger, push_i, pop_i, commit, squash;
    logic [31:0] data_i;

    logic        ready, valid, ovf, unf;
    logic [31:0] top;
    logic [4:0]  spec_cnt, cmt_cnt;
    logic [3:0]  pend_cnt;

    logic        ready_w, valid_w, ovf_w, unf_w;
    logic [31:0] top_w;
    logic [2:0]  spec_cnt_w, cmt_cnt_w;
    logic [3:0]  pend_cnt_w;

    logic        ready_d, valid_d, ovf_d, unf_d;
    logic [31:0] top_d;
    logic [2:0]  spec_cnt_d, cmt_cnt_d;
    logic [3:0]  pend_cnt_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ras_spec_stack u_dut (
        .clk(clk), .reset(reset), .trigger(trigger), .push_i(push_i), .pop_i(pop_i),
        .data_i(data_i), .ready_o(ready), .commit(commit), .squash(squash),
        .top_o(top), .valid_o(valid), .spec_count_o(spec_cnt), .cmt_count_o(cmt_cnt),
        .pend_count_o(pend_cnt), .overflow_o(ovf), .underflow_o(unf)
    );

    ras_spec_stack #(.DEPTH(4), .OVF_WRAP(1'b1)) u_w4 (
        .clk(clk), .reset(reset), .trigger(trigger), .push_i(push_i), .pop_i(pop_i),
        .data_i(data_i), .ready_o(ready_w), .commit(commit), .squash(squash),
        .top_o(top_w), .valid_o(valid_w), .spec_count_o(spec_cnt_w), .cmt_count_o(cmt_cnt_w),
        .pend_count_o(pend_cnt_w), .overflow_o(ovf_w), .underflow_o(unf_w)
    );

    ras_spec_stack #(.DEPTH(4), .OVF_WRAP(1'b0)) u_d4 (
        .clk(clk), .reset(reset), .trigger(trigger), .push_i(push_i), .pop_i(pop_i),
        .data_i(data_i), .ready_o(ready_d), .commit(commit), .squash(squash),
        .top_o(top_d), .valid_o(valid_d), .spec_count_o(spec_cnt_d), .cmt_count_o(cmt_cnt_d),
        .pend_count_o(pend_cnt_d), .overflow_o(ovf_d), .underflow_o(unf_d)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs, then return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        trigger = 1'b0; push_i = 1'b0; pop_i = 1'b0; commit = 1'b0; squash = 1'b0;
        data_i = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic act(input logic pu, input logic po, input logic [31:0] d,
                       input logic cm, input logic sq);
        trigger = pu | po; push_i = pu; pop_i = po; data_i = d; commit = cm; squash = sq;
        tick();
    endtask

    logic [31:0] exp_w [4];
    logic [31:0] exp_d [4];

    initial begin
        trigger = 0; push_i = 0; pop_i = 0; commit = 0; squash = 0; data_i = 0; reset = 1;
        do_reset();

        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_top", top, 0);
        check("rst_spec", spec_cnt, 0);
        check("rst_cmt", cmt_cnt, 0);
        check("rst_pend", pend_cnt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);

        // Three pushes, commit them, pop twice, squash back.
        act(1, 0, 32'h100, 0, 0); check("push1_top", top, 32'h100);
        act(1, 0, 32'h200, 0, 0); check("push2_top", top, 32'h200);
        act(1, 0, 32'h300, 0, 0); check("push3_top", top, 32'h300);
        check("push3_spec", spec_cnt, 3);
        check("push3_cmt", cmt_cnt, 0);
        check("push3_pend", pend_cnt, 3);
        for (int i = 0; i < 3; i++) act(0, 0, 0, 1, 0);
        check("cmt3_cmt", cmt_cnt, 3);
        check("cmt3_pend", pend_cnt, 0);
        act(0, 1, 0, 0, 0);
        act(0, 1, 0, 0, 0);
        check("pop2_top", top, 32'h100);
        check("pop2_spec", spec_cnt, 1);
        act(0, 0, 0, 0, 1);
        check("sq1_top", top, 32'h300);
        check("sq1_spec", spec_cnt, 3);
        check("sq1_pend", pend_cnt, 0);

        // A speculative push after a pop must not corrupt the committed entry.
        do_reset();
        act(1, 0, 32'hA, 0, 0);
        act(0, 0, 0, 1, 0);
        act(0, 1, 0, 0, 0);
        act(1, 0, 32'hB, 0, 0);
        check("rb_top_pre", top, 32'hB);
        act(0, 0, 0, 0, 1);
        check("rb_top", top, 32'hA);
        check("rb_spec", spec_cnt, 1);
        check("rb_pend", pend_cnt, 0);

        // Overflow on DEPTH=4: wrap overwrites the oldest, drop discards the push.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            act(1, 0, 32'(i), 0, 0);
            if (i == 4) begin
                check("ovf_w_early", ovf_w, 0);
                check("ovf_d_early", ovf_d, 0);
            end
        end
        check("ovf_w_pulse", ovf_w, 1);
        check("ovf_d_pulse", ovf_d, 1);
        check("ovf_w_spec", spec_cnt_w, 4);
        check("ovf_d_spec", spec_cnt_d, 4);
        check("ovf_main_none", ovf, 0);
        tick();
        check("ovf_w_clear", ovf_w, 0);
        check("ovf_d_clear", ovf_d, 0);
        exp_w = '{32'd5, 32'd4, 32'd3, 32'd2};
        exp_d = '{32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_pop%0d", i), top_w, exp_w[i]);
            check($sformatf("drop_pop%0d", i), top_d, exp_d[i]);
            act(0, 1, 0, 1, 0);
        end
        check("wrap_empty_valid", valid_w, 0);
        check("wrap_empty_top", top_w, 0);
        check("drop_empty_spec", spec_cnt_d, 0);

        // Underflow, NOP commit and replace.
        do_reset();
        act(0, 1, 0, 0, 0);
        check("unf_pulse", unf, 1);
        check("unf_pend", pend_cnt, 1);
        check("unf_spec", spec_cnt, 0);
        tick();
        check("unf_clear", unf, 0);
        act(0, 0, 0, 1, 0);
        check("unf_cmt", cmt_cnt, 0);
        check("unf_pend0", pend_cnt, 0);
        act(1, 1, 32'h7, 0, 0);
        check("repl0_spec", spec_cnt, 1);
        check("repl0_top", top, 32'h7);
        act(1, 1, 32'h9, 0, 0);
        check("repl1_top", top, 32'h9);
        check("repl1_spec", spec_cnt, 1);
        act(0, 0, 0, 1, 0);
        act(0, 0, 0, 1, 0);
        check("repl_cmt", cmt_cnt, 1);
        act(0, 0, 0, 0, 1);
        check("repl_sq_top", top, 32'h9);
        check("repl_sq_spec", spec_cnt, 1);

        // Pending-queue back-pressure and commit/squash interaction.
        do_reset();
        for (int i = 0; i < 8; i++) act(1, 0, 32'h10 + 32'(i), 0, 0);
        check("full_ready", ready, 0);
        check("full_pend", pend_cnt, 8);
        check("full_spec", spec_cnt, 8);
        act(1, 0, 32'h99, 0, 0);
        check("full_ign_pend", pend_cnt, 8);
        check("full_ign_spec", spec_cnt, 8);
        check("full_ign_top", top, 32'h17);
        act(0, 0, 0, 1, 0);
        check("full_cmt_pend", pend_cnt, 7);
        check("full_cmt_ready", ready, 1);
        act(1, 0, 32'h55, 1, 0);
        check("tc_pend", pend_cnt, 7);
        check("tc_spec", spec_cnt, 9);
        check("tc_top", top, 32'h55);
        check("tc_cmt", cmt_cnt, 2);
        act(1, 0, 32'h66, 1, 1);
        check("csq_cmt", cmt_cnt, 3);
        check("csq_spec", spec_cnt, 3);
        check("csq_top", top, 32'h12);
        check("csq_pend", pend_cnt, 0);

        // Reset mid-operation wins over a simultaneous push.
        reset = 1'b1;
        act(1, 0, 32'h77, 0, 0);
        reset = 1'b0;
        check("midrst_spec", spec_cnt, 0);
        check("midrst_cmt", cmt_cnt, 0);
        check("midrst_pend", pend_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
